// File: rtl/pusch_hop_seq_ctrl_pkg.sv
// Shared constants, encodings and helpers for the DMRS hopping control sequencer.
package pusch_hop_seq_ctrl_pkg;

  localparam int unsigned NC          = 1600;
  localparam int unsigned N_SYMB_SLOT = 14;
  localparam int unsigned SLOT_W      = 5;
  localparam int unsigned CNT_W       = 13;
  localparam int unsigned QUOT_W      = 6;
  localparam int unsigned NID_W       = 10;
  localparam int unsigned LFSR_W      = 31;
  localparam int unsigned BIDX_W      = 3;

  typedef enum logic [1:0] {
    ALL_DIS = 2'd0,
    GH_EN   = 2'd1,
    SH_EN   = 2'd2
  } hop_mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIV     = 3'd1,
    LOAD    = 3'd2,
    WARM    = 3'd3,
    COLLECT = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Sequence offset of the first collected bit; wraps modulo 2^CNT_W.
  function automatic logic [CNT_W-1:0] calc_offset(input hop_mode_e m,
                                                   input logic [SLOT_W-1:0] ns,
                                                   input logic [3:0] l);
    logic [CNT_W-1:0] s;
    s = CNT_W'(N_SYMB_SLOT) * CNT_W'(ns) + CNT_W'(l);
    return (m == GH_EN) ? (s << 3) : s;
  endfunction

endpackage

// File: rtl/gold_lfsr.sv
// Length-31 Gold sequence generator: x1/x2 registers with load and single-step advance.
module gold_lfsr
  import pusch_hop_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] x2_init,
  output logic              out_bit_c
);

  logic [LFSR_W-1:0] x1_q;
  logic [LFSR_W-1:0] x2_q;

  // Bit 0 holds x(n); each step shifts in x(n+31).
  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q <= '0;
      x2_q <= '0;
    end else if (load) begin
      x1_q <= LFSR_W'(1);
      x2_q <= x2_init;
    end else if (step) begin
      x1_q <= {x1_q[3] ^ x1_q[0], x1_q[LFSR_W-1:1]};
      x2_q <= {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[LFSR_W-1:1]};
    end
  end

  assign out_bit_c = x1_q[0] ^ x2_q[0];

endmodule

// File: rtl/pusch_hop_seq_ctrl.sv
// DMRS group/sequence hopping control-bit sequencer.
// Optional SEQ_CACHE_EN: reuse the LFSR state of the previous run when the
// new request continues the same sequence at or beyond the position reached.
module pusch_hop_seq_ctrl
  import pusch_hop_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NID_W-1:0]  n_ID,
  input  logic [1:0]        En_hopping,
  input  logic [SLOT_W-1:0] slot_num,
  input  logic [3:0]        symb_idx,
  output logic              busy,
  output logic [7:0]        c,
  output logic              c_valid,
  output logic [NID_W-1:0]  n_ID_o,
  output logic [1:0]        hop_mode_o
);

  state_e             state;
  logic [CNT_W-1:0]   offset_q;
  logic [NID_W-1:0]   rem_q;
  logic [QUOT_W-1:0]  quot_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIDX_W-1:0]  bidx_q;

  hop_mode_e          req_mode_c;
  hop_mode_e          cur_mode_c;
  logic [LFSR_W-1:0]  cinit_c;
  logic [CNT_W-1:0]   target_c;
  logic [CNT_W-1:0]   skip_c;
  logic [BIDX_W-1:0]  last_bit_c;
  logic               hit_c;
  logic               lfsr_load_c;
  logic               lfsr_step_c;
  logic               lfsr_bit_c;

  assign req_mode_c  = (En_hopping == 2'd3) ? ALL_DIS : hop_mode_e'(En_hopping);
  assign cur_mode_c  = hop_mode_e'(hop_mode_o);
  assign cinit_c     = (cur_mode_c == GH_EN) ? LFSR_W'(quot_q) : LFSR_W'(n_ID_o);
  assign target_c    = CNT_W'(NC) + offset_q;
  assign last_bit_c  = (cur_mode_c == GH_EN) ? BIDX_W'(7) : BIDX_W'(0);

`ifdef SEQ_CACHE_EN
  logic              cache_valid;
  hop_mode_e         cache_mode;
  logic [LFSR_W-1:0] cache_cinit;
  logic [CNT_W-1:0]  cache_pos;

  assign hit_c  = cache_valid && (cache_mode == cur_mode_c) &&
                  (cache_cinit == cinit_c) && (target_c >= cache_pos);
  assign skip_c = hit_c ? (target_c - cache_pos) : target_c;

  // The LFSR registers are left untouched between runs, so they hold the cached x1/x2.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_mode  <= ALL_DIS;
      cache_cinit <= '0;
      cache_pos   <= '0;
    end else if (state == COLLECT && bidx_q == last_bit_c) begin
      cache_valid <= 1'b1;
      cache_mode  <= cur_mode_c;
      cache_cinit <= cinit_c;
      cache_pos   <= target_c + CNT_W'(last_bit_c) + CNT_W'(1);
    end
  end
`else
  assign hit_c  = 1'b0;
  assign skip_c = target_c;
`endif

  assign lfsr_load_c = (state == LOAD) && !hit_c;
  assign lfsr_step_c = (state == WARM) || (state == COLLECT);

  gold_lfsr u_gold_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (lfsr_load_c),
    .step      (lfsr_step_c),
    .x2_init   (cinit_c),
    .out_bit_c (lfsr_bit_c)
  );

  // Request sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      c          <= '0;
      c_valid    <= 1'b0;
      n_ID_o     <= '0;
      hop_mode_o <= '0;
      offset_q   <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      bidx_q     <= '0;
    end else begin
      c_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_ID_o     <= n_ID;
            hop_mode_o <= req_mode_c;
            offset_q   <= calc_offset(req_mode_c, slot_num, symb_idx);
            rem_q      <= n_ID;
            quot_q     <= '0;
            bidx_q     <= '0;
            c          <= '0;
            case (req_mode_c)
              GH_EN: begin
                state <= DIV;
                busy  <= 1'b1;
              end
              SH_EN: begin
                state <= LOAD;
                busy  <= 1'b1;
              end
              default: begin
                state   <= DONE;
                c_valid <= 1'b1;
              end
            endcase
          end
        end
        DIV: begin
          if (rem_q >= NID_W'(30)) begin
            rem_q  <= rem_q - NID_W'(30);
            quot_q <= quot_q + QUOT_W'(1);
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          cnt_q <= skip_c;
          state <= (skip_c == '0) ? COLLECT : WARM;
        end
        WARM: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= COLLECT;
        end
        COLLECT: begin
          c[bidx_q] <= lfsr_bit_c;
          bidx_q    <= bidx_q + BIDX_W'(1);
          if (bidx_q == last_bit_c) begin
            state   <= DONE;
            busy    <= 1'b0;
            c_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pusch_hop_seq_ctrl.sv
// Directed self-checking bench for pusch_hop_seq_ctrl (optional SEQ_CACHE_EN path).
module tb_pusch_hop_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] n_ID;
  logic [1:0] En_hopping;
  logic [4:0] slot_num;
  logic [3:0] symb_idx;
  logic       busy;
  logic [7:0] c;
  logic       c_valid;
  logic [9:0] n_ID_o;
  logic [1:0] hop_mode_o;

  int compared;
  int mismatched;

  bit mx1 [0:5400];
  bit mx2 [0:5400];

  pusch_hop_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_ID       (n_ID),
    .En_hopping (En_hopping),
    .slot_num   (slot_num),
    .symb_idx   (symb_idx),
    .busy       (busy),
    .c          (c),
    .c_valid    (c_valid),
    .n_ID_o     (n_ID_o),
    .hop_mode_o (hop_mode_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Gold sequence straight from the recurrence definitions.
  function automatic logic [7:0] model_c(input int cinit, input int off, input int nbits);
    logic [7:0] r;
    int last;
    last = 1600 + off + nbits;
    for (int n = 0; n < 31; n++) begin
      mx1[n] = (n == 0);
      mx2[n] = ((cinit >> n) & 1) != 0;
    end
    for (int n = 0; n + 31 <= last; n++) begin
      mx1[n+31] = mx1[n+3] ^ mx1[n];
      mx2[n+31] = mx2[n+3] ^ mx2[n+2] ^ mx2[n+1] ^ mx2[n];
    end
    r = 8'h00;
    for (int i = 0; i < nbits; i++) r[i] = mx1[1600+off+i] ^ mx2[1600+off+i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request; returns cycle of c_valid (or -1) and busy seen at cycle 1.
  task automatic do_req(input logic [1:0] m, input logic [9:0] nid, input logic [4:0] ns,
                        input logic [3:0] l, output int t, output logic b1);
    @(negedge clk);
    En_hopping = m; n_ID = nid; slot_num = ns; symb_idx = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b1 = busy;
    t = -1;
    for (int k = 1; k <= 6000; k++) begin
      if (c_valid) begin
        t = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int   t;
  logic b1;
  int   hits;
  logic [7:0] exp_c;

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; start = 1'b0; n_ID = '0; En_hopping = '0; slot_num = '0; symb_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_c_valid", 32'(c_valid), 0);
    check("rst_c", 32'(c), 0);
    check("rst_n_ID_o", 32'(n_ID_o), 0);
    check("rst_hop_mode_o", 32'(hop_mode_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Disabled mode; start held into DONE must be ignored.
    En_hopping = 2'd0; n_ID = 10'd517; start = 1'b1;
    @(negedge clk);
    check("dis_c_valid_cyc1", 32'(c_valid), 1);
    check("dis_busy", 32'(busy), 0);
    check("dis_c", 32'(c), 0);
    check("dis_hop_mode_o", 32'(hop_mode_o), 0);
    check("dis_n_ID_o", 32'(n_ID_o), 517);
    @(negedge clk);
    start = 1'b0;
    check("dis_start_in_done_ignored", 32'(c_valid), 0);
    repeat (3) @(negedge clk);
    check("dis_no_extra_valid", 32'(c_valid), 0);

    // Mode 3 behaves as disabled.
    do_req(2'd3, 10'd12, 5'd0, 4'd0, t, b1);
    check("mode3_latency", 32'(t), 1);
    check("mode3_hop_mode_o", 32'(hop_mode_o), 0);

    // Group hop, c_init=0, offset 0.
    do_req(2'd1, 10'd0, 5'd0, 4'd0, t, b1);
    check("gh0_busy_cyc1", 32'(b1), 1);
    check("gh0_latency", 32'(t), 1611);
    check("gh0_busy_at_valid", 32'(busy), 0);
    check("gh0_c", 32'(c), 32'(model_c(0, 0, 8)));
    check("gh0_hop_mode_o", 32'(hop_mode_o), 1);
    @(negedge clk);
    check("gh0_valid_one_cycle", 32'(c_valid), 0);
    check("gh0_c_hold", 32'(c), 32'(model_c(0, 0, 8)));

    // Group hop at the largest in-range offset, q=33.
    do_req(2'd1, 10'd1007, 5'd19, 4'd13, t, b1);
    check("gh1007_latency", 32'(t), 3876);
    check("gh1007_c", 32'(c), 32'(model_c(33, 2232, 8)));
    check("gh1007_n_ID_o", 32'(n_ID_o), 1007);

    // Sequence hop, c_init=n_ID.
    do_req(2'd2, 10'd300, 5'd3, 4'd5, t, b1);
    check("sh300_latency", 32'(t), 1650);
    check("sh300_c", 32'(c), 32'(model_c(300, 47, 1)));
    check("sh300_hop_mode_o", 32'(hop_mode_o), 2);

    // Start while busy is ignored, then reset aborts mid-WARM.
    @(negedge clk);
    En_hopping = 2'd1; n_ID = 10'd0; slot_num = 5'd0; symb_idx = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    En_hopping = 2'd0; n_ID = 10'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored_mode", 32'(hop_mode_o), 1);
    check("busy_start_ignored_nid", 32'(n_ID_o), 0);
    check("busy_start_ignored_busy", 32'(busy), 1);
    check("busy_start_ignored_valid", 32'(c_valid), 0);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_c_valid", 32'(c_valid), 0);
    check("abort_c", 32'(c), 0);
    check("abort_n_ID_o", 32'(n_ID_o), 0);
    check("abort_hop_mode_o", 32'(hop_mode_o), 0);
    hits = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (c_valid) hits++;
    end
    check("abort_no_c_valid", 32'(hits), 0);
    do_req(2'd2, 10'd300, 5'd3, 4'd5, t, b1);
    check("post_abort_latency", 32'(t), 1650);
    check("post_abort_c", 32'(c), 32'(model_c(300, 47, 1)));

    // Consecutive symbols in the same slot, n_ID=60 (q=2).
    do_req(2'd1, 10'd60, 5'd0, 4'd0, t, b1);
    check("gh60_l0_latency", 32'(t), 1613);
    exp_c = model_c(2, 0, 8);
    check("gh60_l0_c", 32'(c), 32'(exp_c));
    do_req(2'd1, 10'd60, 5'd0, 4'd1, t, b1);
`ifdef SEQ_CACHE_EN
    check("gh60_l1_latency", 32'(t), 13);
`else
    check("gh60_l1_latency", 32'(t), 1621);
`endif
    exp_c = model_c(2, 8, 8);
    check("gh60_l1_c", 32'(c), 32'(exp_c));

    // Different c_init after that must take the full path.
    do_req(2'd1, 10'd90, 5'd0, 4'd2, t, b1);
    check("gh90_latency", 32'(t), 1+4+1+1616+8);
    exp_c = model_c(3, 16, 8);
    check("gh90_c", 32'(c), 32'(exp_c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
